kf_seq_ctrl: RTL

- Sequencer for one kf_scalar core, used as the front end of every filter instance.
- The core's state recurrence is loop-carried over its internal pipeline. This block therefore serialises samples: one measurement in flight at a time.
- It also owns init and Q/R configuration, applying changes only between samples.
- It provides valid/ready handshakes on both sides and a watchdog on the core's result.

---
 rtl/kf_pkg.sv | 18 +
 rtl/kf_seq_ctrl.sv | 130 +++++++++++++
 2 files changed

// File: rtl/kf_pkg.sv
// kf_pkg: shared widths, fixed-point constants and sequencer state encoding
package kf_pkg;
    localparam int WX = 16;
    localparam int WP = 32;
    localparam int WF_X = 15;
    localparam int WF_P = 29;
    localparam logic [31:0] ONE = 32'h2000_0000;
    localparam logic [15:0] X0_DEF = 16'h0000;
    localparam logic [31:0] P0_DEF = ONE;
    localparam logic [31:0] Q_DEF = ONE;
    localparam logic [31:0] R_DEF = ONE;
    typedef enum logic [1:0] {
        INIT  = 2'd0,
        IDLE  = 2'd1,
        ISSUE = 2'd2,
        WAIT  = 2'd3
    } seq_state_t;
endpackage

// File: rtl/kf_seq_ctrl.sv
// kf_seq_ctrl: serialises samples into one kf_scalar core, owns init/Q/R config and watches the result
module kf_seq_ctrl #(
    parameter int WX = kf_pkg::WX,
    parameter int WP = kf_pkg::WP,
    parameter int CORE_LAT = 10,
    parameter int TO_CYC = 32,
    parameter int SEQW = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            s_valid,
    output logic            s_ready,
    input  logic [WX-1:0]   s_z,
    input  logic            cfg_we,
    input  logic [WX-1:0]   cfg_x0,
    input  logic [WP-1:0]   cfg_P0,
    input  logic [WP-1:0]   cfg_Q,
    input  logic [WP-1:0]   cfg_R,
    input  logic            cfg_init,
    output logic            k_s_valid,
    output logic [WX-1:0]   k_z,
    output logic            k_load_init,
    output logic [WX-1:0]   k_x0,
    output logic [WP-1:0]   k_P0,
    output logic [WP-1:0]   k_Q,
    output logic [WP-1:0]   k_R,
    input  logic            k_m_valid,
    output logic            k_m_ready,
    input  logic [WX-1:0]   k_x_hat,
    output logic            m_valid,
    input  logic            m_ready,
    output logic [WX-1:0]   m_x,
    output logic [SEQW-1:0] m_seq,
    output logic            busy,
    output logic            err_timeout,
    input  logic            err_clr
);
    import kf_pkg::*;

    localparam int WDW = $clog2(TO_CYC + 1);

    if (TO_CYC <= CORE_LAT + 2) begin : g_to_check
        $error("TO_CYC must exceed CORE_LAT+2");
    end

    seq_state_t      state, state_nx;
    logic [WX-1:0]   sh_x0;
    logic [WP-1:0]   sh_p0, sh_q, sh_r;
    logic            init_pend;
    logic [WDW-1:0]  wd;
    logic [SEQW-1:0] seq_cnt;
    logic            capture, timeout;

    assign k_x0 = sh_x0;
    assign k_P0 = sh_p0;
    assign busy = state != IDLE;

    // next state and per-state handshake strobes
    always_comb begin
        state_nx = state;
        s_ready = 1'b0;
        k_s_valid = 1'b0;
        k_load_init = 1'b0;
        k_m_ready = 1'b0;
        capture = 1'b0;
        timeout = 1'b0;
        case (state)
            INIT: begin
                k_load_init = !rst;
                state_nx = IDLE;
            end
            IDLE: begin
                s_ready = !(init_pend || cfg_init) && (!m_valid || m_ready);
                state_nx = (init_pend || cfg_init) ? INIT : (s_valid && s_ready) ? ISSUE : IDLE;
            end
            ISSUE: begin
                k_s_valid = 1'b1;
                state_nx = WAIT;
            end
            WAIT: begin
                k_m_ready = 1'b1;
                capture = k_m_valid;
                timeout = !k_m_valid && (wd == WDW'(TO_CYC - 1));
                state_nx = capture ? IDLE : timeout ? INIT : WAIT;
            end
            default: state_nx = INIT;
        endcase
    end

    // state, config shadow/active registers, watchdog and result holding register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= INIT;
            sh_x0 <= WX'(X0_DEF);
            sh_p0 <= WP'(P0_DEF);
            sh_q <= WP'(Q_DEF);
            sh_r <= WP'(R_DEF);
            k_Q <= WP'(Q_DEF);
            k_R <= WP'(R_DEF);
            init_pend <= 1'b0;
            k_z <= '0;
            wd <= '0;
            m_valid <= 1'b0;
            m_x <= '0;
            m_seq <= '0;
            seq_cnt <= '0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nx;
            if (cfg_we) begin
                sh_x0 <= cfg_x0;
                sh_p0 <= cfg_P0;
                sh_q <= cfg_Q;
                sh_r <= cfg_R;
            end
            if (state == INIT || state == IDLE) begin
                k_Q <= sh_q;
                k_R <= sh_r;
            end
            init_pend <= (cfg_init && state != IDLE) ? 1'b1 : (state == INIT) ? 1'b0 : init_pend;
            if (state == IDLE && s_valid && s_ready) k_z <= s_z;
            wd <= (state == ISSUE) ? '0 : (state == WAIT && wd != WDW'(TO_CYC)) ? wd + 1'b1 : wd;
            m_valid <= capture || (m_valid && !m_ready);
            if (capture) m_x <= k_x_hat;
            m_seq <= (state == INIT) ? '0 : capture ? seq_cnt : m_seq;
            seq_cnt <= (state == INIT) ? '0 : capture ? seq_cnt + 1'b1 : seq_cnt;
            err_timeout <= timeout || (err_timeout && !err_clr);
        end
    end
endmodule
